frame_buf_ctrl: RTL and testbench
=================================

# frame_buf_ctrl

Double-buffer write controller between `capture` and the two-bank frame BRAM. It converts the `capture` pixel stream (`o_wr`/`o_wdata`/`o_sof`) into bank-addressed BRAM writes and chooses which bank each new frame lands in. It hands completed frames to a single downstream reader (color-detect pipeline) through a grant/release handshake, so the reader never sees a bank being written. Frames that are truncated by a new start-of-frame or by disable are discarded and counted.

## Interface
- `FRAME_PIXELS`, default 307200: pixels per complete frame (640x480).
- `ADDR_W`, default 19: per-bank pixel address width; must satisfy 2^ADDR_W >= FRAME_PIXELS.
- `i_pclk`  in  1: camera pixel clock; the only clock.
- `i_rstn`  in  1: asynchronous, active-low reset.
- `i_enable`  in  1: capture enable, level.
- `i_sof`  in  1: one-cycle start-of-frame pulse from `capture.o_sof`.
- `i_wr`  in  1: pixel valid from `capture.o_wr`.
- `i_wdata`  in  16: RGB565 pixel from `capture.o_wdata`.
- `o_bram_we`  out  1: BRAM write enable.
- `o_bram_waddr`  out  ADDR_W+1: {bank, pixel index}.
- `o_bram_wdata`  out  16: BRAM write data.
- `i_rd_req`  in  1: reader requests a completed frame, level; held until granted.
- `o_rd_valid`  out  1: grant active; bank in `o_rd_bank` is locked for reading.
- `o_rd_bank`  out  1: granted bank.
- `i_rd_done`  in  1: one-cycle release of the granted bank.
- `o_busy`  out  1: high while in WRITE.
- `o_abort_cnt`  out  8: saturating count of discarded (truncated) frames.

## Operation
- State machine: IDLE, ARMED, WRITE.
- IDLE: entered when `i_enable`=0 or after reset. Goes to ARMED when `i_enable`=1.
- ARMED: `i_wr` is ignored.
  - On `i_sof`, select the write bank `wb`, clear `full[wb]`, set the pixel count to 0, and go to WRITE.
- WRITE: each `i_wr` writes the pixel to `{wb, cnt}`, then `cnt++`.
  - The write with `cnt == FRAME_PIXELS-1` completes the frame: set `full[wb]`, set `latest = wb`, go to ARMED.
- Bank selection at `i_sof`:
  - If a grant is held, use `~o_rd_bank`. This can overwrite the newest completed frame; that loss is intended.
  - Otherwise use `~latest`, so the newest complete frame is preserved.
- Truncation:
  - `i_sof` in WRITE before completion: the partial bank stays not-full, `o_abort_cnt` increments, and the new frame starts in the same cycle with bank reselection.
  - `i_enable`=0 in WRITE: the partial bank stays not-full, `o_abort_cnt` increments, and the state goes to IDLE.
- `i_sof` and `i_wr` in the same cycle: `i_sof` is processed and that `i_wr` is dropped.
- `o_abort_cnt` saturates at 255.
- Reader handshake:
  - Grant condition: `i_rd_req`=1, `o_rd_valid`=0, and some `full[b]`=1. Grant `latest` if `full[latest]`, else the other bank.
  - `i_rd_done` while `o_rd_valid`: clear `o_rd_valid` and clear `full[o_rd_bank]`.
  - `i_rd_done` while not valid: ignored.
  - Reader logic is independent of the write FSM state, including IDLE.

## Timing
- Reset (asynchronous, `i_rstn`=0) sets:
  - state IDLE, `full`=0, `latest`=0, `cnt`=0;
  - all outputs 0: `o_bram_we`, `o_bram_waddr`, `o_bram_wdata`, `o_rd_valid`, `o_rd_bank`, `o_busy`, `o_abort_cnt`.
- Write path latency is 1 cycle: `i_wr` at edge N gives `o_bram_we`/`o_bram_waddr`/`o_bram_wdata` valid after edge N+1. All three outputs are registered together.
- `o_bram_we` is a single-cycle pulse per accepted pixel. There are no writes outside WRITE.
- `full`/`latest` update at the completing edge. A request in that same cycle is evaluated against the pre-update flags and is granted on the next edge if `i_rd_req` is still high.
- Grant latency: `o_rd_valid` rises on the edge after the grant condition is true.
- Release: `o_rd_valid` falls on the edge after `i_rd_done`. A new grant is possible no earlier than the following edge.
- `o_busy` is registered from the state (high in WRITE).

## Test plan
All scenarios use `FRAME_PIXELS`=16 and `ADDR_W`=4.
- Reset, enable, `i_sof`, then 16 `i_wr` pixels 0x0000..0x000F:
  - `o_bram_waddr` is 0x10..0x1F (bank 1, since `latest`=0), each one cycle after its `i_wr`;
  - `full[1]`=1, state returns to ARMED;
  - `o_rd_valid` rises on the next edge after `i_rd_req`, with `o_rd_bank`=1.
- Hold the grant on bank 1 and send two more full frames:
  - both are written to bank 0 (addresses 0x00..0x0F);
  - `i_rd_done` clears `o_rd_valid`;
  - the next `i_rd_req` is granted bank 0.
- `i_sof` after 10 pixels:
  - `o_abort_cnt`=1;
  - the new frame restarts at address index 0 in the reselected bank;
  - the truncated bank is never granted.
- Drop `i_enable` after 5 pixels:
  - no `o_bram_we` after 1 cycle;
  - state IDLE, `o_abort_cnt`=1, `o_busy`=0.
- `i_sof` and `i_wr` in the same cycle in ARMED: no BRAM write. The first write lands on index 0 from the next `i_wr`.
- Assert `i_rstn`=0 mid-frame (pixel 7) with a grant held: all outputs are 0 immediately; after release, `i_rd_req` gets no grant until a full frame completes.
- Send 300 truncated frames: `o_abort_cnt` saturates at 255.

Source files
------------

// File: rtl/frame_buf_ctrl.sv
// rtl/frame_buf_ctrl.sv - double-buffer BRAM write controller with single-reader grant/release
module frame_buf_ctrl #(
   parameter int FRAME_PIXELS = 307200,
   parameter int ADDR_W       = 19
) (
   input  logic              i_pclk,
   input  logic              i_rstn,
   input  logic              i_enable,
   input  logic              i_sof,
   input  logic              i_wr,
   input  logic [15:0]       i_wdata,
   output logic              o_bram_we,
   output logic [ADDR_W:0]   o_bram_waddr,
   output logic [15:0]       o_bram_wdata,
   input  logic              i_rd_req,
   output logic              o_rd_valid,
   output logic              o_rd_bank,
   input  logic              i_rd_done,
   output logic              o_busy,
   output logic [7:0]        o_abort_cnt
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_PIXELS - 1);

   typedef enum logic [1:0] {IDLE, ARMED, WRITE} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] cnt;
   logic              wb;
   logic [1:0]        full;
   logic              latest;
   logic              start, accept, abort, last_px, sel_bank, grant, release_g;

   assign last_px = (cnt == LAST_IDX);

   always_ff @(posedge i_pclk or negedge i_rstn) begin
      if (!i_rstn) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (i_enable) state_nxt = ARMED;
         ARMED:   if (!i_enable) state_nxt = IDLE;
                  else if (i_sof) state_nxt = WRITE;
         WRITE:   if (!i_enable) state_nxt = IDLE;
                  else if (i_sof) state_nxt = WRITE;
                  else if (i_wr && last_px) state_nxt = ARMED;
         default: state_nxt = IDLE;
      endcase
   end

   // A start-of-frame always wins over a pixel in the same cycle; that pixel is dropped.
   always_comb begin
      start     = i_enable && i_sof && (state == ARMED || state == WRITE);
      accept    = (state == WRITE) && i_enable && !i_sof && i_wr;
      abort     = (state == WRITE) && (!i_enable || i_sof);
      sel_bank  = o_rd_valid ? ~o_rd_bank : ~latest;
      grant     = i_rd_req && !o_rd_valid && (full != 2'b00);
      release_g = i_rd_done && o_rd_valid;
   end

   always_ff @(posedge i_pclk or negedge i_rstn) begin
      if (!i_rstn) begin
         o_bram_we    <= 1'b0;
         o_bram_waddr <= '0;
         o_bram_wdata <= '0;
         o_rd_valid   <= 1'b0;
         o_rd_bank    <= 1'b0;
         o_busy       <= 1'b0;
         o_abort_cnt  <= '0;
         cnt          <= '0;
         wb           <= 1'b0;
         full         <= 2'b00;
         latest       <= 1'b0;
      end else begin
         o_bram_we <= accept;
         o_busy    <= (state_nxt == WRITE);
         if (start) begin
            wb             <= sel_bank;
            cnt            <= '0;
            full[sel_bank] <= 1'b0;
         end
         if (accept) begin
            o_bram_waddr <= {wb, cnt};
            o_bram_wdata <= i_wdata;
            if (last_px) begin
               cnt      <= '0;
               full[wb] <= 1'b1;
               latest   <= wb;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
         if (abort && o_abort_cnt != 8'hFF) o_abort_cnt <= o_abort_cnt + 8'd1;
         // Reader sees the flags as they were before this edge's frame completion.
         if (grant) begin
            o_rd_valid <= 1'b1;
            o_rd_bank  <= full[latest] ? latest : ~latest;
         end else if (release_g) begin
            o_rd_valid      <= 1'b0;
            full[o_rd_bank] <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_frame_buf_ctrl.sv
// tb/tb_frame_buf_ctrl.sv - self-checking bench for frame_buf_ctrl (table, scenarios, random vs model)
module tb_frame_buf_ctrl;
   localparam int FP = 16;
   localparam int AW = 4;

   logic        i_pclk = 1'b0;
   logic        i_rstn = 1'b0;
   logic        i_enable = 1'b0, i_sof = 1'b0, i_wr = 1'b0, i_rd_req = 1'b0, i_rd_done = 1'b0;
   logic [15:0] i_wdata = 16'h0;
   logic        o_bram_we, o_rd_valid, o_rd_bank, o_busy;
   logic [AW:0] o_bram_waddr;
   logic [15:0] o_bram_wdata;
   logic [7:0]  o_abort_cnt;

   always #5 i_pclk = ~i_pclk;

   frame_buf_ctrl #(.FRAME_PIXELS(FP), .ADDR_W(AW)) dut (
      .i_pclk(i_pclk), .i_rstn(i_rstn), .i_enable(i_enable), .i_sof(i_sof), .i_wr(i_wr),
      .i_wdata(i_wdata), .o_bram_we(o_bram_we), .o_bram_waddr(o_bram_waddr),
      .o_bram_wdata(o_bram_wdata), .i_rd_req(i_rd_req), .o_rd_valid(o_rd_valid),
      .o_rd_bank(o_rd_bank), .i_rd_done(i_rd_done), .o_busy(o_busy), .o_abort_cnt(o_abort_cnt)
   );

   int errors = 0;
   int checks = 0;

   // Behavioural model: phase 0 = disabled, 1 = waiting for a frame, 2 = receiving a frame.
   int          m_phase, m_cnt, m_abort;
   bit          m_wbank, m_latest, m_valid, m_rbank, m_we;
   bit          m_full [2];
   logic [4:0]  m_addr;
   logic [15:0] m_data;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   task automatic model_reset();
      m_phase = 0; m_cnt = 0; m_abort = 0; m_wbank = 0; m_latest = 0;
      m_valid = 0; m_rbank = 0; m_we = 0; m_full[0] = 0; m_full[1] = 0;
      m_addr = '0; m_data = '0;
   endtask

   task automatic abort_inc();
      if (m_abort < 255) m_abort++;
   endtask

   task automatic model_step();
      bit f0, f1, lat0, v0, rb0;
      f0 = m_full[0]; f1 = m_full[1]; lat0 = m_latest; v0 = m_valid; rb0 = m_rbank;
      m_we = 0;
      if (!i_enable) begin
         if (m_phase == 2) abort_inc();
         m_phase = 0;
      end else if (m_phase == 0) begin
         m_phase = 1;
      end else if (i_sof) begin
         if (m_phase == 2) abort_inc();
         m_wbank = v0 ? !rb0 : !lat0;
         m_full[m_wbank] = 0;
         m_cnt = 0;
         m_phase = 2;
      end else if (m_phase == 2 && i_wr) begin
         m_we = 1;
         m_addr = 5'(int'(m_wbank) * FP + m_cnt);
         m_data = i_wdata;
         m_cnt++;
         if (m_cnt == FP) begin
            m_full[m_wbank] = 1;
            m_latest = m_wbank;
            m_phase = 1;
         end
      end
      if (i_rd_req && !v0 && (f0 || f1)) begin
         m_valid = 1;
         m_rbank = (lat0 ? f1 : f0) ? lat0 : !lat0;
      end else if (i_rd_done && v0) begin
         m_valid = 0;
         m_full[rb0] = 0;
      end
   endtask

   function automatic logic [32:0] exp_vec();
      return {m_we, m_addr, m_data, m_valid, m_rbank, (m_phase == 2), 8'(m_abort)};
   endfunction

   function automatic logic [32:0] dut_vec();
      return {o_bram_we, o_bram_waddr, o_bram_wdata, o_rd_valid, o_rd_bank, o_busy, o_abort_cnt};
   endfunction

   task automatic cycle(input string name);
      model_step();
      @(posedge i_pclk);
      #1;
      chk(name, dut_vec(), exp_vec());
   endtask

   task automatic set_in(input logic en, input logic sof, input logic wr, input logic [15:0] wd,
                         input logic req, input logic done);
      i_enable = en; i_sof = sof; i_wr = wr; i_wdata = wd; i_rd_req = req; i_rd_done = done;
   endtask

   task automatic do_reset(input string name);
      @(posedge i_pclk);
      #2;
      i_rstn = 1'b0;
      set_in(0, 0, 0, 16'h0, 0, 0);
      #1;
      model_reset();
      chk(name, dut_vec(), 33'h0);
      @(posedge i_pclk);
      #1;
      i_rstn = 1'b1;
   endtask

   task automatic send_frame(input int n, input logic [15:0] base);
      i_sof = 1; i_wr = 0;
      cycle("sof");
      i_sof = 0;
      for (int p = 0; p < n; p++) begin
         i_wr = 1; i_wdata = base + 16'(p);
         cycle("pix");
         if (p == 0) chk("first_pix_idx", o_bram_waddr[AW-1:0], 4'h0);
      end
      i_wr = 0;
   endtask

   typedef struct packed {
      logic        en, sof, wr;
      logic [15:0] wd;
      logic        req, done;
      logic        we;
      logic [4:0]  addr;
      logic [15:0] data;
      logic        busy;
      logic [7:0]  abort;
      logic        valid;
   } vec_t;

   vec_t tbl [10];

   initial begin
      tbl[0] = '{1, 0, 0, 16'h0000, 0, 0,  0, 5'h00, 16'h0000, 0, 8'd0, 0};
      tbl[1] = '{1, 1, 1, 16'hDEAD, 0, 0,  0, 5'h00, 16'h0000, 1, 8'd0, 0};
      tbl[2] = '{1, 0, 1, 16'hA000, 0, 0,  1, 5'h10, 16'hA000, 1, 8'd0, 0};
      tbl[3] = '{1, 0, 0, 16'h0000, 0, 0,  0, 5'h10, 16'hA000, 1, 8'd0, 0};
      tbl[4] = '{1, 0, 1, 16'hA001, 0, 0,  1, 5'h11, 16'hA001, 1, 8'd0, 0};
      tbl[5] = '{1, 1, 0, 16'h0000, 0, 0,  0, 5'h11, 16'hA001, 1, 8'd1, 0};
      tbl[6] = '{1, 0, 1, 16'hB000, 0, 0,  1, 5'h10, 16'hB000, 1, 8'd1, 0};
      tbl[7] = '{0, 0, 0, 16'h0000, 0, 0,  0, 5'h10, 16'hB000, 0, 8'd2, 0};
      tbl[8] = '{0, 0, 1, 16'h1234, 0, 0,  0, 5'h10, 16'hB000, 0, 8'd2, 0};
      tbl[9] = '{0, 0, 0, 16'h0000, 1, 0,  0, 5'h10, 16'hB000, 0, 8'd2, 0};

      model_reset();
      #12;
      chk("reset_state", dut_vec(), 33'h0);
      @(posedge i_pclk);
      #1;
      i_rstn = 1'b1;

      for (int i = 0; i < 10; i++) begin
         set_in(tbl[i].en, tbl[i].sof, tbl[i].wr, tbl[i].wd, tbl[i].req, tbl[i].done);
         cycle($sformatf("tbl_model%0d", i));
         chk($sformatf("tbl%0d", i),
             {o_bram_we, o_bram_waddr, o_bram_wdata, o_busy, o_abort_cnt, o_rd_valid},
             {tbl[i].we, tbl[i].addr, tbl[i].data, tbl[i].busy, tbl[i].abort, tbl[i].valid});
      end

      // Full frame into bank 1, then grant.
      do_reset("reset_a");
      set_in(1, 0, 0, 16'h0, 0, 0);
      cycle("arm");
      send_frame(FP, 16'h0000);
      chk("frame1_last_addr", o_bram_waddr, 5'h1F);
      chk("frame1_busy_off", o_busy, 1'b0);
      i_rd_req = 1;
      cycle("req1");
      chk("grant_bank1", {o_rd_valid, o_rd_bank}, 2'b11);
      i_rd_req = 0;

      // Two frames while bank 1 is held both go to bank 0.
      send_frame(FP, 16'h0100);
      chk("frame2_last_addr", o_bram_waddr, 5'h0F);
      send_frame(FP, 16'h0200);
      chk("frame3_last_addr", o_bram_waddr, 5'h0F);
      chk("grant_still_held", {o_rd_valid, o_rd_bank}, 2'b11);
      i_rd_done = 1;
      cycle("done1");
      chk("release", o_rd_valid, 1'b0);
      i_rd_done = 0;
      i_rd_req = 1;
      cycle("req2");
      chk("grant_bank0", {o_rd_valid, o_rd_bank}, 2'b10);
      i_rd_req = 0;

      // Reset mid-frame with the grant held; nothing is grantable afterwards.
      send_frame(7, 16'h0300);
      do_reset("reset_midframe");
      set_in(1, 0, 0, 16'h0, 1, 0);
      for (int k = 0; k < 4; k++) cycle("req_after_reset");
      chk("no_grant_after_reset", o_rd_valid, 1'b0);
      i_rd_req = 0;

      // Enable dropped after 5 pixels.
      send_frame(5, 16'h0400);
      i_enable = 0;
      cycle("disable");
      chk("disable_state", {o_bram_we, o_busy, o_abort_cnt}, {1'b0, 1'b0, 8'd1});
      cycle("disable2");

      // Truncation by sof after 10 pixels restarts at index 0; truncated bank is never granted.
      do_reset("reset_b");
      set_in(1, 0, 0, 16'h0, 0, 0);
      cycle("arm2");
      send_frame(10, 16'h0500);
      send_frame(FP, 16'h0600);
      chk("trunc_abort", o_abort_cnt, 8'd1);
      chk("trunc_restart_addr", o_bram_waddr, 5'h1F);
      i_rd_req = 1;
      cycle("req3");
      chk("grant_complete_only", {o_rd_valid, o_rd_bank}, 2'b11);
      i_rd_req = 0; i_rd_done = 1;
      cycle("done3");
      i_rd_done = 0; i_rd_req = 1;
      for (int k = 0; k < 3; k++) cycle("req_none");
      chk("no_grant_truncated", o_rd_valid, 1'b0);
      i_rd_req = 0;

      // Saturation of the abort counter.
      for (int f = 0; f < 300; f++) send_frame(2, 16'h0700);
      i_enable = 0;
      cycle("sat_disable");
      chk("abort_saturated", o_abort_cnt, 8'd255);

      // Randomized traffic against the model.
      do_reset("reset_c");
      for (int c = 0; c < 3000; c++) begin
         set_in($urandom_range(0, 99) < 97, $urandom_range(0, 99) < 3,
                $urandom_range(0, 99) < 80, 16'($urandom),
                $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 10);
         cycle("rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
